// File: rtl/hysteresis_comparator.sv
// Multi-channel streaming threshold comparator with hysteresis and
// a persistence counter; registered state plus rise/fall pulses.
module hysteresis_comparator #(
    parameter int DATA_WIDTH  = 16,
    parameter int N_CHANNELS  = 2,
    parameter int SIGNED      = 0,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [N_CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                             s_axis_tvalid,
    input  logic [2:0]                       op,
    input  logic [DATA_WIDTH-1:0]            threshold,
    input  logic [DATA_WIDTH-1:0]            hysteresis,
    input  logic [COUNT_WIDTH-1:0]           hold_count,
    input  logic                             clear,
    output logic [N_CHANNELS-1:0]            m_axis_tdata,
    output logic                             m_axis_tvalid,
    output logic [N_CHANNELS-1:0]            rise,
    output logic [N_CHANNELS-1:0]            fall
);

    // Two guard bits keep threshold +/- hysteresis exact for either signedness.
    localparam int EW = DATA_WIDTH + 2;

    localparam logic [2:0] OP_GE = 3'd0;
    localparam logic [2:0] OP_GT = 3'd1;
    localparam logic [2:0] OP_LE = 3'd2;
    localparam logic [2:0] OP_LT = 3'd3;
    localparam logic [2:0] OP_EQ = 3'd4;
    localparam logic [2:0] OP_NE = 3'd5;

    function automatic logic signed [EW-1:0] ext(
        input logic [DATA_WIDTH-1:0] v
    );
        if (SIGNED != 0) begin
            ext = {{2{v[DATA_WIDTH-1]}}, v};
        end else begin
            ext = {2'b00, v};
        end
    endfunction

    logic signed [EW-1:0]   w_thr;
    logic signed [EW-1:0]   w_hys;
    logic signed [EW-1:0]   w_smp [N_CHANNELS];
    logic signed [EW-1:0]   w_eff [N_CHANNELS];
    logic [N_CHANNELS-1:0]  w_cand;

    logic [N_CHANNELS-1:0]  r_state;
    logic [COUNT_WIDTH-1:0] r_cnt [N_CHANNELS];
    logic [N_CHANNELS-1:0]  r_rise;
    logic [N_CHANNELS-1:0]  r_fall;
    logic                   r_valid;

    assign w_thr = ext(threshold);
    assign w_hys = {2'b00, hysteresis};

    always_comb begin
        for (int k = 0; k < N_CHANNELS; k++) begin
            w_smp[k] = ext(s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH]);
            w_eff[k] = w_thr;
            if (r_state[k]) begin
                if (op == OP_GE || op == OP_GT) begin
                    w_eff[k] = w_thr - w_hys;
                end else if (op == OP_LE || op == OP_LT) begin
                    w_eff[k] = w_thr + w_hys;
                end
            end
            case (op)
                OP_GE:   w_cand[k] = (w_smp[k] >= w_eff[k]);
                OP_GT:   w_cand[k] = (w_smp[k] >  w_eff[k]);
                OP_LE:   w_cand[k] = (w_smp[k] <= w_eff[k]);
                OP_LT:   w_cand[k] = (w_smp[k] <  w_eff[k]);
                OP_EQ:   w_cand[k] = (w_smp[k] == w_eff[k]);
                OP_NE:   w_cand[k] = (w_smp[k] != w_eff[k]);
                default: w_cand[k] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            r_valid <= 1'b0;
            for (int k = 0; k < N_CHANNELS; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            r_valid <= s_axis_tvalid & ~clear;
            r_rise  <= '0;
            r_fall  <= '0;
            if (clear) begin
                r_state <= '0;
                for (int k = 0; k < N_CHANNELS; k++) begin
                    r_cnt[k] <= '0;
                end
            end else if (s_axis_tvalid) begin
                for (int k = 0; k < N_CHANNELS; k++) begin
                    if (w_cand[k] == r_state[k]) begin
                        r_cnt[k] <= '0;
                    end else if (r_cnt[k] >= hold_count) begin
                        // >= so a lowered hold_count takes effect at once
                        r_state[k] <= w_cand[k];
                        r_cnt[k]   <= '0;
                        r_rise[k]  <= w_cand[k];
                        r_fall[k]  <= ~w_cand[k];
                    end else begin
                        r_cnt[k] <= r_cnt[k] + COUNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    assign m_axis_tdata  = r_state;
    assign m_axis_tvalid = r_valid;
    assign rise          = r_rise;
    assign fall          = r_fall;

endmodule

// File: tb/tb_hysteresis_comparator.sv
// Directed self-checking bench for hysteresis_comparator
// (unsigned and signed instances driven from the same stimulus).
module tb_hysteresis_comparator;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic [2:0]  op;
    logic [15:0] threshold;
    logic [15:0] hysteresis;
    logic [7:0]  hold_count;
    logic        clear;

    logic [1:0]  u_tdata, u_rise, u_fall;
    logic        u_tvalid;
    logic [1:0]  s_tdata, s_rise, s_fall;
    logic        s_tvalid;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    hysteresis_comparator #(
        .DATA_WIDTH(16), .N_CHANNELS(2), .SIGNED(0), .COUNT_WIDTH(8)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .op(op), .threshold(threshold), .hysteresis(hysteresis),
        .hold_count(hold_count), .clear(clear),
        .m_axis_tdata(u_tdata), .m_axis_tvalid(u_tvalid),
        .rise(u_rise), .fall(u_fall)
    );

    hysteresis_comparator #(
        .DATA_WIDTH(16), .N_CHANNELS(2), .SIGNED(1), .COUNT_WIDTH(8)
    ) dut_s (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .op(op), .threshold(threshold), .hysteresis(hysteresis),
        .hold_count(hold_count), .clear(clear),
        .m_axis_tdata(s_tdata), .m_axis_tvalid(s_tvalid),
        .rise(s_rise), .fall(s_fall)
    );

    // Apply one cycle of input, then sample the registered result.
    task automatic send(input logic [15:0] d0, input logic [15:0] d1,
                        input logic v, input logic clr);
        @(negedge aclk);
        s_axis_tdata  = {d1, d0};
        s_axis_tvalid = v;
        clear         = clr;
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        clear         = 1'b0;
    endtask

    task automatic cfg(input logic [2:0] o, input logic [15:0] t,
                       input logic [15:0] h, input logic [7:0] hc);
        op = o; threshold = t; hysteresis = h; hold_count = hc;
        send(16'd0, 16'd0, 1'b0, 1'b1);
    endtask

    task automatic test_reset;
        aresetn = 1'b0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; clear = 1'b0;
        op = 3'd0; threshold = '0; hysteresis = '0; hold_count = '0;
        #12;
        checks++;
        if ({u_tdata, u_tvalid, u_rise, u_fall} !== 7'd0) begin
            $display("FAIL reset_u got=%b exp=0",
                     {u_tdata, u_tvalid, u_rise, u_fall});
            errors++;
        end
        checks++;
        if ({s_tdata, s_tvalid, s_rise, s_fall} !== 7'd0) begin
            $display("FAIL reset_s got=%b exp=0",
                     {s_tdata, s_tvalid, s_rise, s_fall});
            errors++;
        end
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic test_ge;
        logic [15:0] smp [4] = '{16'd99, 16'd100, 16'd101, 16'd99};
        logic [5:0]  exp [4] = '{6'b00_00_00, 6'b01_01_00,
                                 6'b01_00_00, 6'b00_00_01};
        cfg(3'd0, 16'd100, 16'd0, 8'd0);
        for (int i = 0; i < 4; i++) begin
            send(smp[i], 16'd0, 1'b1, 1'b0);
            checks++;
            if ({u_tdata, u_rise, u_fall} !== exp[i] || u_tvalid !== 1'b1) begin
                $display("FAIL ge[%0d] got=%b v=%b exp=%b v=1",
                         i, {u_tdata, u_rise, u_fall}, u_tvalid, exp[i]);
                errors++;
            end
        end
    endtask

    task automatic test_hysteresis;
        logic [15:0] smp [4] = '{16'd100, 16'd95, 16'd90, 16'd89};
        logic [5:0]  exp [4] = '{6'b01_01_00, 6'b01_00_00,
                                 6'b01_00_00, 6'b00_00_01};
        cfg(3'd0, 16'd100, 16'd10, 8'd0);
        for (int i = 0; i < 4; i++) begin
            send(smp[i], 16'd0, 1'b1, 1'b0);
            checks++;
            if ({u_tdata, u_rise, u_fall} !== exp[i]) begin
                $display("FAIL hyst[%0d] got=%b exp=%b",
                         i, {u_tdata, u_rise, u_fall}, exp[i]);
                errors++;
            end
        end
        // Unsigned release offset larger than the threshold must not wrap.
        cfg(3'd0, 16'd5, 16'hFFFF, 8'd0);
        send(16'd5, 16'd0, 1'b1, 1'b0);
        send(16'd0, 16'd0, 1'b1, 1'b0);
        checks++;
        if ({u_tdata, u_fall} !== 4'b01_00) begin
            $display("FAIL hyst_nowrap got=%b exp=0100", {u_tdata, u_fall});
            errors++;
        end
    endtask

    task automatic test_persistence;
        logic [15:0] smp [6] = '{16'd60, 16'd60, 16'd40,
                                 16'd60, 16'd60, 16'd60};
        logic [5:0]  exp [6] = '{6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b01_01_00};
        logic        gv  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        cfg(3'd0, 16'd50, 16'd0, 8'd2);
        for (int i = 0; i < 6; i++) begin
            send(smp[i], 16'd0, 1'b1, 1'b0);
            checks++;
            if ({u_tdata, u_rise, u_fall} !== exp[i]) begin
                $display("FAIL persist[%0d] got=%b exp=%b",
                         i, {u_tdata, u_rise, u_fall}, exp[i]);
                errors++;
            end
        end
        // Same run of three 60s, now interleaved with idle cycles.
        cfg(3'd0, 16'd50, 16'd0, 8'd2);
        for (int i = 0; i < 6; i++) begin
            send(16'd60, 16'd0, gv[i], 1'b0);
            checks++;
            if (u_tvalid !== gv[i] ||
                {u_tdata, u_rise} !== ((i == 5) ? 4'b01_01 : 4'b00_00)) begin
                $display("FAIL persist_gap[%0d] got=%b v=%b exp_v=%b",
                         i, {u_tdata, u_rise}, u_tvalid, gv[i]);
                errors++;
            end
        end
        // Lowering hold_count below the running count changes state at once.
        cfg(3'd0, 16'd50, 16'd0, 8'd3);
        send(16'd60, 16'd0, 1'b1, 1'b0);
        send(16'd60, 16'd0, 1'b1, 1'b0);
        hold_count = 8'd1;
        send(16'd60, 16'd0, 1'b1, 1'b0);
        checks++;
        if ({u_tdata, u_rise} !== 4'b01_01) begin
            $display("FAIL persist_lower got=%b exp=0101", {u_tdata, u_rise});
            errors++;
        end
    endtask

    task automatic test_signed;
        cfg(3'd3, 16'h8000, 16'hFFFF, 8'd0);
        send(16'h8000, 16'd0, 1'b1, 1'b0);
        checks++;
        if ({s_tdata, s_rise} !== 4'b00_00) begin
            $display("FAIL signed_min got=%b exp=0000", {s_tdata, s_rise});
            errors++;
        end
        threshold = 16'hFFFF;
        send(16'h8000, 16'd0, 1'b1, 1'b0);
        checks++;
        if ({s_tdata, s_rise} !== 4'b01_01) begin
            $display("FAIL signed_lt got=%b exp=0101", {s_tdata, s_rise});
            errors++;
        end
        // Release point is -1 + 65535 = 65534, beyond any 16-bit signed sample.
        send(16'h7FFF, 16'd0, 1'b1, 1'b0);
        checks++;
        if ({s_tdata, s_fall} !== 4'b01_00) begin
            $display("FAIL signed_hold got=%b exp=0100", {s_tdata, s_fall});
            errors++;
        end
    endtask

    task automatic test_multi_invalid_op;
        cfg(3'd4, 16'd7, 16'd0, 8'd0);
        send(16'd7, 16'd8, 1'b1, 1'b0);
        checks++;
        if ({u_tdata, u_rise} !== 4'b01_01) begin
            $display("FAIL multi_eq got=%b exp=0101", {u_tdata, u_rise});
            errors++;
        end
        op = 3'd6;
        send(16'd7, 16'd8, 1'b1, 1'b0);
        checks++;
        if ({u_tdata, u_rise, u_fall} !== 6'b00_00_01) begin
            $display("FAIL multi_badop got=%b exp=000001",
                     {u_tdata, u_rise, u_fall});
            errors++;
        end
    endtask

    task automatic test_clear_reset;
        cfg(3'd0, 16'd0, 16'd0, 8'd0);
        send(16'd5, 16'd5, 1'b1, 1'b0);
        checks++;
        if ({u_tdata, u_rise} !== 4'b11_11) begin
            $display("FAIL clr_setup got=%b exp=1111", {u_tdata, u_rise});
            errors++;
        end
        send(16'd5, 16'd5, 1'b1, 1'b1);
        checks++;
        if ({u_tdata, u_tvalid, u_rise, u_fall} !== 7'd0) begin
            $display("FAIL clear got=%b exp=0",
                     {u_tdata, u_tvalid, u_rise, u_fall});
            errors++;
        end
        send(16'd5, 16'd5, 1'b1, 1'b0);
        @(negedge aclk);
        #2;
        aresetn = 1'b0;
        #1;
        checks++;
        if ({u_tdata, u_tvalid, u_rise, u_fall} !== 7'd0) begin
            $display("FAIL async_reset got=%b exp=0",
                     {u_tdata, u_tvalid, u_rise, u_fall});
            errors++;
        end
        @(negedge aclk);
        aresetn = 1'b1;
        send(16'd5, 16'd5, 1'b1, 1'b0);
        checks++;
        if ({u_tdata, u_tvalid, u_rise} !== 5'b11_1_11) begin
            $display("FAIL post_reset got=%b exp=11111",
                     {u_tdata, u_tvalid, u_rise});
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_ge();
        test_hysteresis();
        test_persistence();
        test_signed();
        test_multi_invalid_op();
        test_clear_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
